// File: rtl/apb_adc_sampler_if.sv
// APB3 slave-side bus bundle for the ADC sampler.
// The master modport drives the request; the slave modport returns data and status.
interface apb_adc_sampler_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_adc_sampler.sv
// APB slave that scans an external ADC across the enabled mux channels at a
// programmable rate and queues channel-tagged samples in a FIFO with a level/overflow irq.
module apb_adc_sampler #(
  parameter  int DATA_WIDTH = 12,
  parameter  int NUM_CH     = 4,
  parameter  int FIFO_DEPTH = 16,
  parameter  int DIV_WIDTH  = 16,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  RSTn,
  apb_adc_sampler_if.slave      apb,
  input  logic [DATA_WIDTH-1:0] adc_data,
  output logic [CH_W-1:0]       adc_ch,
  output logic                  irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = CH_W + DATA_WIDTH;

  typedef enum logic {S_IDLE = 1'b0, S_SCAN = 1'b1} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_en;
  logic                r_cont;
  logic                r_irq_en;
  logic [NUM_CH-1:0]   r_mask;
  logic [DIV_WIDTH-1:0] r_div;
  logic [DIV_WIDTH-1:0] r_cnt;
  logic [7:0]          r_thresh;
  logic                r_ovf;
  logic [CH_W-1:0]     r_ch;
  logic                r_irq;
  logic [EW-1:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic [CW-1:0]       r_count;

  function automatic logic [CH_W-1:0] f_low_ch(input logic [NUM_CH-1:0] mask);
    logic [CH_W-1:0] ch;
    ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (mask[i]) ch = CH_W'(i);
    return ch;
  endfunction

  // Returns {wrapped, channel}: next enabled channel above cur, else the lowest one.
  function automatic logic [CH_W:0] f_next_ch(input logic [CH_W-1:0] cur,
                                              input logic [NUM_CH-1:0] mask);
    logic            found;
    logic [CH_W-1:0] ch;
    found = 1'b0;
    ch    = f_low_ch(mask);
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (mask[i] && (i > int'(cur))) begin
        ch    = CH_W'(i);
        found = 1'b1;
      end
    return {~found, ch};
  endfunction

  logic [5:0]        w_off;
  logic              w_access;
  logic              w_bad;
  logic              w_wr;
  logic              w_rd;
  logic              w_wr_ctrl;
  logic              w_wr_div;
  logic              w_wr_stat;
  logic              w_wr_thr;
  logic              w_rd_data;
  logic [NUM_CH-1:0] w_wmask;
  logic              w_wen;
  logic              w_flush;
  logic              w_unused;

  assign w_off     = apb.PADDR[7:2];
  assign w_access  = apb.PSEL & apb.PENABLE;
  assign w_bad     = w_off > 6'd4;
  assign w_wr      = w_access & apb.PWRITE & ~w_bad;
  assign w_rd      = w_access & ~apb.PWRITE & ~w_bad;
  assign w_wr_ctrl = w_wr & (w_off == 6'd0);
  assign w_wr_div  = w_wr & (w_off == 6'd1);
  assign w_wr_stat = w_wr & (w_off == 6'd2);
  assign w_wr_thr  = w_wr & (w_off == 6'd4);
  assign w_rd_data = w_rd & (w_off == 6'd3);
  assign w_wmask   = apb.PWDATA[16 +: NUM_CH];
  // An enable with no channel selected is stored as disabled.
  assign w_wen     = apb.PWDATA[0] & (|w_wmask);
  assign w_flush   = w_wr_ctrl & apb.PWDATA[2];
  assign w_unused  = ^{apb.PWDATA, apb.PADDR[1:0]};

  logic            w_empty;
  logic            w_full;
  logic [7:0]      w_count8;
  logic [EW-1:0]   w_head;
  logic [CH_W:0]   w_adv;
  logic            w_adv_wrap;
  logic [CH_W-1:0] w_adv_ch;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_count8   = 8'(r_count);
  assign w_head     = r_mem[r_rptr];
  assign w_adv      = f_next_ch(r_ch, r_mask);
  assign w_adv_wrap = w_adv[CH_W];
  assign w_adv_ch   = w_adv[CH_W-1:0];

  // ---- scan FSM: state register ----
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  logic w_capture;
  logic w_enter;
  logic w_busy;
  logic w_done;

  // ---- scan FSM: next state ----
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_wr_ctrl && w_wen) w_state_nxt = S_SCAN;
      S_SCAN: if ((w_wr_ctrl && !w_wen) || w_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---- scan FSM: outputs ----
  always_comb begin
    w_capture = (r_state == S_SCAN) && (r_cnt == '0);
    w_enter   = (r_state == S_IDLE) && w_wr_ctrl && w_wen;
    w_busy    = (r_state != S_IDLE);
    w_done    = w_capture && w_adv_wrap && !r_cont;
  end

  logic w_pop;
  logic w_push;
  logic w_ovf_set;

  // Flush swallows any same-cycle push or pop; a pop frees room for a push when full.
  assign w_pop     = w_rd_data & ~w_empty & ~w_flush;
  assign w_push    = w_capture & ~w_flush & (~w_full | w_pop);
  assign w_ovf_set = w_capture & ~w_flush & w_full & ~w_pop;

  // ---- control / status registers ----
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_en     <= 1'b0;
      r_cont   <= 1'b0;
      r_irq_en <= 1'b0;
      r_mask   <= '0;
      r_div    <= '0;
      r_thresh <= '0;
      r_ovf    <= 1'b0;
      r_cnt    <= '0;
      r_ch     <= '0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_cont   <= apb.PWDATA[1];
        r_irq_en <= apb.PWDATA[3];
        r_mask   <= w_wmask;
      end
      r_en <= (w_state_nxt == S_SCAN);
      if (w_wr_div) r_div    <= apb.PWDATA[DIV_WIDTH-1:0];
      if (w_wr_thr) r_thresh <= apb.PWDATA[7:0];

      if (w_ovf_set)                          r_ovf <= 1'b1;
      else if (w_wr_stat && apb.PWDATA[2])    r_ovf <= 1'b0;

      if (w_enter || w_capture)  r_cnt <= r_div;
      else if (r_state == S_SCAN) r_cnt <= r_cnt - 1'b1;

      // A finished single pass leaves the mux on the last channel sampled.
      if (w_enter)                   r_ch <= f_low_ch(w_wmask);
      else if (w_capture && !w_done) r_ch <= w_adv_ch;

      r_irq <= r_irq_en & (r_ovf | ((r_thresh != 8'd0) && (w_count8 >= r_thresh)));
    end
  end

  // ---- sample FIFO ----
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {r_ch, adc_data};
  end

  // ---- APB read mux ----
  logic [31:0] w_rdata;

  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      case (w_off)
        6'd0: begin
          w_rdata[0]           = r_en;
          w_rdata[1]           = r_cont;
          w_rdata[3]           = r_irq_en;
          w_rdata[16 +: NUM_CH] = r_mask;
        end
        6'd1: w_rdata[DIV_WIDTH-1:0] = r_div;
        6'd2: begin
          w_rdata[0]    = w_empty;
          w_rdata[1]    = w_full;
          w_rdata[2]    = r_ovf;
          w_rdata[3]    = w_busy;
          w_rdata[15:8] = w_count8;
        end
        6'd3: if (!w_empty) begin
          w_rdata[31]               = 1'b1;
          w_rdata[16 +: CH_W]       = w_head[EW-1 -: CH_W];
          w_rdata[DATA_WIDTH-1:0]   = w_head[DATA_WIDTH-1:0];
        end
        6'd4: w_rdata[7:0] = r_thresh;
        default: ;
      endcase
    end
  end

  assign apb.PRDATA  = w_rdata;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = w_access & w_bad;
  assign adc_ch      = r_ch;
  assign irq         = r_irq;

endmodule

// File: tb/tb_apb_adc_sampler.sv
// Bench for apb_adc_sampler: register table vectors, then scan/FIFO/irq sequences
// checked against an expected-sample queue filled as captures are provoked.
module tb_apb_adc_sampler;
  logic        clk = 1'b0;
  logic        RSTn = 1'b0;
  logic [11:0] adc_data;
  logic [1:0]  adc_ch;
  logic        irq;

  apb_adc_sampler_if bus();

  apb_adc_sampler #(
    .DATA_WIDTH(12), .NUM_CH(4), .FIFO_DEPTH(16), .DIV_WIDTH(16)
  ) dut (
    .clk(clk), .RSTn(RSTn), .apb(bus), .adc_data(adc_data), .adc_ch(adc_ch), .irq(irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] sb_q[$];

  typedef struct {
    logic [7:0]  addr;
    bit          wr;
    logic [31:0] wdata;
    logic [31:0] exp;
    bit          exp_err;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  // Called at edge+1; the access phase ends (takes effect) two edges later.
  task automatic apb_xfer(input logic [7:0] addr, input bit wr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr; bus.PADDR = addr; bus.PWDATA = wdata;
    @(posedge clk); #1;
    bus.PENABLE = 1'b1;
    #1;
    rdata = bus.PRDATA;
    err   = bus.PSLVERR;
    @(posedge clk); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] d);
    logic [31:0] rd_v;
    logic        e;
    apb_xfer(addr, 1'b1, d, rd_v, e);
    chk($sformatf("wr%02h_err", addr), 32'(e), 32'd0);
  endtask

  task automatic rd_chk(input string name, input logic [7:0] addr, input logic [31:0] exp);
    logic [31:0] rd_v;
    logic        e;
    apb_xfer(addr, 1'b0, 32'd0, rd_v, e);
    chk(name, rd_v, exp);
  endtask

  task automatic sb_data(input string name);
    logic [31:0] exp;
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : 32'd0;
    rd_chk(name, 8'h0C, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic [31:0] rv;
    logic        re;

    tbl[0]  = '{8'h00, 1'b0, 32'h0,        32'h0,        1'b0};
    tbl[1]  = '{8'h04, 1'b0, 32'h0,        32'h0,        1'b0};
    tbl[2]  = '{8'h08, 1'b0, 32'h0,        32'h1,        1'b0};
    tbl[3]  = '{8'h0C, 1'b0, 32'h0,        32'h0,        1'b0};
    tbl[4]  = '{8'h10, 1'b0, 32'h0,        32'h0,        1'b0};
    tbl[5]  = '{8'h14, 1'b0, 32'h0,        32'h0,        1'b1};
    tbl[6]  = '{8'h04, 1'b1, 32'h0005_1234, 32'h0,       1'b0};
    tbl[7]  = '{8'h04, 1'b0, 32'h0,        32'h1234,     1'b0};
    tbl[8]  = '{8'h10, 1'b1, 32'h0000_01A5, 32'h0,       1'b0};
    tbl[9]  = '{8'h10, 1'b0, 32'h0,        32'hA5,       1'b0};
    tbl[10] = '{8'h14, 1'b1, 32'hFFFF_FFFF, 32'h0,       1'b1};
    tbl[11] = '{8'h04, 1'b0, 32'h0,        32'h1234,     1'b0};
    tbl[12] = '{8'h00, 1'b1, 32'h0000_000B, 32'h0,       1'b0};
    tbl[13] = '{8'h00, 1'b0, 32'h0,        32'h0000_000A, 1'b0};
    tbl[14] = '{8'h08, 1'b0, 32'h0,        32'h1,        1'b0};
    tbl[15] = '{8'h00, 1'b1, 32'h0,        32'h0,        1'b0};
    tbl[16] = '{8'h04, 1'b1, 32'h3,        32'h0,        1'b0};
    tbl[17] = '{8'h10, 1'b1, 32'h0,        32'h0,        1'b0};
    tbl[18] = '{8'h10, 1'b0, 32'h0,        32'h0,        1'b0};
    tbl[19] = '{8'hFC, 1'b0, 32'h0,        32'h0,        1'b1};

    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = 8'h0; bus.PWDATA = 32'h0;
    adc_data = 12'h0;
    repeat (3) @(posedge clk);
    #1 RSTn = 1'b1;
    wait_cyc(1);

    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_adc_ch", 32'(adc_ch), 32'd0);
    chk("rst_pready", 32'(bus.PREADY), 32'd1);
    chk("rst_pslverr", 32'(bus.PSLVERR), 32'd0);
    chk("rst_prdata", bus.PRDATA, 32'd0);

    for (int i = 0; i < 20; i++) begin
      apb_xfer(tbl[i].addr, tbl[i].wr, tbl[i].wdata, rv, re);
      chk($sformatf("vec%0d_err", i), 32'(re), 32'(tbl[i].exp_err));
      if (!tbl[i].wr) chk($sformatf("vec%0d_rdata", i), rv, tbl[i].exp);
    end

    // Single pass over ch1 and ch3, DIV=3
    adc_data = 12'h123;
    wr(8'h00, 32'h000A_0001);
    sb_q.push_back(32'h8001_0123);
    sb_q.push_back(32'h8003_0123);
    chk("pass_ch_start", 32'(adc_ch), 32'd1);
    wait_cyc(3);
    chk("pass_ch_before_cap", 32'(adc_ch), 32'd1);
    wait_cyc(1);
    chk("pass_ch_adv", 32'(adc_ch), 32'd3);
    wait_cyc(4);
    chk("pass_ch_hold", 32'(adc_ch), 32'd3);
    rd_chk("pass_status", 8'h08, 32'h0000_0200);
    rd_chk("pass_ctrl", 8'h00, 32'h000A_0000);
    sb_data("pass_data0");
    sb_data("pass_data1");
    sb_data("pass_data_empty");
    rd_chk("pass_status_empty", 8'h08, 32'h0000_0001);

    // Continuous scan at DIV=0 into a FIFO with no pops -> overflow
    wr(8'h04, 32'h0);
    wr(8'h00, 32'h0001_000B);
    for (int k = 1; k <= 18; k++) begin
      adc_data = 12'(256 + k);
      @(posedge clk); #1;
      if (k <= 16) sb_q.push_back(32'h8000_0000 | 32'(256 + k));
      if (k >= 16) chk($sformatf("ovf_irq_k%0d", k), 32'(irq), (k == 18) ? 32'd1 : 32'd0);
    end
    wr(8'h00, 32'h0001_0008);
    rd_chk("ovf_status", 8'h08, 32'h0000_1006);
    chk("ovf_irq_held", 32'(irq), 32'd1);
    wr(8'h08, 32'h4);
    chk("ovf_clr_irq_lag", 32'(irq), 32'd1);
    wait_cyc(1);
    chk("ovf_clr_irq_drop", 32'(irq), 32'd0);
    rd_chk("ovf_clr_status", 8'h08, 32'h0000_1002);

    // Full FIFO: DATA pop lands on the same edge as a capture
    wr(8'h04, 32'h3);
    adc_data = 12'h3C3;
    wr(8'h00, 32'h0001_0003);
    wait_cyc(2);
    sb_data("full_pop_oldest");
    sb_q.push_back(32'h8000_03C3);
    wr(8'h00, 32'h0);
    rd_chk("full_popcap_status", 8'h08, 32'h0000_1002);
    for (int i = 0; i < 11; i++) sb_data($sformatf("drain%0d", i));
    rd_chk("drain_status", 8'h08, 32'h0000_0500);
    wr(8'h00, 32'h4);
    sb_q.delete();
    rd_chk("flush_status", 8'h08, 32'h0000_0001);
    sb_data("flush_data_empty");

    // Threshold irq on a single channel, DIV=9
    wr(8'h04, 32'd9);
    wr(8'h10, 32'd4);
    adc_data = 12'h7E5;
    wr(8'h00, 32'h0004_000B);
    repeat (4) sb_q.push_back(32'h8002_07E5);
    wait_cyc(40);
    chk("thr_irq_before", 32'(irq), 32'd0);
    wait_cyc(1);
    chk("thr_irq_rise", 32'(irq), 32'd1);
    sb_data("thr_pop");
    chk("thr_irq_still", 32'(irq), 32'd1);
    wait_cyc(1);
    chk("thr_irq_fall", 32'(irq), 32'd0);
    chk("thr_adc_ch", 32'(adc_ch), 32'd2);

    // Asynchronous reset in the middle of a scan
    #2 RSTn = 1'b0;
    #1;
    chk("arst_irq", 32'(irq), 32'd0);
    chk("arst_adc_ch", 32'(adc_ch), 32'd0);
    chk("arst_pslverr", 32'(bus.PSLVERR), 32'd0);
    @(posedge clk); #1;
    RSTn = 1'b1;
    sb_q.delete();
    wait_cyc(1);
    rd_chk("arst_status", 8'h08, 32'h0000_0001);
    rd_chk("arst_ctrl", 8'h00, 32'h0);
    rd_chk("arst_div", 8'h04, 32'h0);
    rd_chk("arst_thresh", 8'h10, 32'h0);
    sb_data("arst_data");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/apb_adc_sampler.md
Name: apb_adc_sampler

Overview:
- APB slave that time-multiplexes an external ADC across up to NUM_CH channels.
- Samples at a programmable rate and buffers tagged samples in a FIFO.
- Raises a level/overflow interrupt for the CPU.
- Generalised successor of the single-register ADC APB slave; sits on an APB slave mux port behind the AHB-to-APB bridge.

Parameters:
- DATA_WIDTH, 12, ADC sample width (1..16).
- NUM_CH, 4, number of multiplexed channels (1..16).
- FIFO_DEPTH, 16, sample FIFO entries; power of 2, 2..128.
- DIV_WIDTH, 16, sample-period divider width.

Ports:
- clk  in  1  clock
- RSTn  in  1  reset
- PSEL  in  1  APB select
- PENABLE  in  1  APB enable
- PWRITE  in  1  APB write
- PADDR  in  8  byte address; word offset is PADDR[7:2]
- PWDATA  in  32  APB write data
- PRDATA  out  32  APB read data
- PREADY  out  1  always 1
- PSLVERR  out  1  error response
- adc_data  in  DATA_WIDTH  ADC conversion result for the channel on adc_ch
- adc_ch  out  max(1,clog2(NUM_CH))  analog mux channel select
- irq  out  1  interrupt, registered

Interface: reset RSTn, asynchronous, active-low; clock clk.

Behaviour:
- Reset values: all registers 0, FIFO empty, state IDLE, adc_ch=0, irq=0, PRDATA=0, PSLVERR=0.
- APB timing: write takes effect at the access phase (PSEL&PENABLE&PWRITE). PRDATA is combinational during the access phase. PREADY=1, so there are no wait states.
- PSLVERR=1 during the access phase for offsets above 0x10; such writes are ignored and reads return 0.
- 0x00 CTRL (RW):
  - bit0 EN.
  - bit1 CONT: 1 = continuous scan, 0 = single pass.
  - bit2 FLUSH: write-1 pulse, reads 0.
  - bit3 IRQ_EN.
  - bits[16+NUM_CH-1:16] channel MASK.
- 0x04 DIV (RW): DIV_WIDTH bits.
- 0x08 STATUS (RO except OVF):
  - bit0 EMPTY, bit1 FULL.
  - bit2 OVF: sticky; writing 1 clears it.
  - bit3 BUSY: state != IDLE.
  - bits[15:8] FIFO count.
- 0x0C DATA (RO):
  - bit31 VALID, bits[19:16] channel tag, bits[DATA_WIDTH-1:0] sample.
  - A read pops one entry when not empty. When empty, returns 0 and does not pop.
- 0x10 THRESH (RW): FIFO level threshold, 8 bits.
- State machine, states IDLE and SCAN:
  - IDLE->SCAN on a CTRL write with EN=1 and MASK!=0. On entry, tick counter loads DIV and adc_ch = lowest enabled channel.
  - A write with EN=1 and MASK=0 stores EN=0 and stays in IDLE.
  - In SCAN, when the counter is nonzero, decrement it.
  - When the counter is 0, capture: push {adc_ch, adc_data}, reload DIV, advance adc_ch to the next higher enabled channel, wrapping to the lowest.
  - Sample period = DIV+1 cycles; first capture occurs DIV+1 cycles after the EN write. DIV=0 captures every cycle.
  - Wrap with CONT=0: pass complete; go to IDLE and clear EN. adc_ch holds its last value.
  - Software EN=0 write during SCAN: go to IDLE next cycle. A capture in the same cycle as the write still pushes.
  - MASK/DIV writes during SCAN take effect at the next reload or advance.
- FIFO:
  - Push while full drops the sample and sets OVF.
  - Push and pop in the same cycle while full: both occur, count unchanged, OVF not set.
  - Push and pop in the same cycle while empty: read returns 0, push lands, count=1.
  - FLUSH empties the FIFO; a push or pop in the same cycle is discarded. OVF is not affected.
  - Count is visible one cycle after a push or pop.
- irq is registered: irq <= IRQ_EN & (OVF | (THRESH!=0 & count>=THRESH)). It deasserts one cycle after the condition clears.
- Reset mid-scan: immediate return to reset values; FIFO contents are lost.

Test Plan:
- Reset, then read all regs -> CTRL=0, DIV=0, STATUS=0x00000001 (EMPTY), DATA=0, irq=0, adc_ch=0.
- MASK=0b1010, DIV=3, CONT=0, EN=1, adc_data=0x123 -> captures at cycles 4 and 8 on ch1 then ch3; BUSY drops; EN reads 0; count=2. DATA reads give 0x80010123 then 0x80030123; a third read gives 0.
- DIV=0, CONT=1, MASK=0b0001, no pops, FIFO_DEPTH=16 -> count reaches 16, FULL=1, OVF=1 on the 17th capture, irq=1 with IRQ_EN. Writing 1 to STATUS bit2 clears OVF; irq drops 1 cycle later once threshold is not met.
- THRESH=4, IRQ_EN=1, DIV=9, single channel -> irq rises the cycle after count becomes 4. Popping one entry -> irq falls.
- FIFO full, DATA read coinciding with a capture -> count stays 16, no OVF, popped value is the oldest entry. FLUSH with 5 entries -> EMPTY=1, count=0.
- EN=1 with MASK=0 -> BUSY=0, EN reads 0. Assert RSTn low mid-scan -> all outputs reset asynchronously, irq=0.
